// File: rtl/execute_cycle.sv
// ---------------------------------------------------------------------------
// execute_cycle
//
// Execute stage of the five-stage RISC-V pipeline. Takes the D/E pipeline
// outputs, resolves operand forwarding, runs the ALU, resolves BEQ branches,
// computes the branch target, and registers the results into the E/M
// pipeline register that feeds the memory stage.
//
// Ports
//   clk, rst       : pipeline clock (rising edge), synchronous active-high
//                    reset that clears the E/M register
//   RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE : decode control
//   ALUControlE    : ALU op (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                    101 SLT, 110 SLL, 111 SRL)
//   RD1_E, RD2_E   : register-file operands
//   Imm_Ext_E      : sign-extended immediate
//   RD_E           : destination register index
//   PCE, PCPlus4E  : PC and PC+4 of the instruction in E
//   ForwardA_E/B_E : forwarding selects (00 RF, 01 ResultW, 10 ALUResultM,
//                    11 RF)
//   ResultW        : writeback result for forwarding
//   PCSrcE         : combinational branch-taken
//   PCTargetE      : combinational PCE + Imm_Ext_E (wraps modulo 2^32)
//   RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM,
//   PCPlus4M       : E/M register outputs
//
// There is no handshake on this stage: the E/M register loads on every
// rising edge. Stalls are handled upstream by bubbling decode.
// ---------------------------------------------------------------------------
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [4:0]  RD_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  // ALU operation encoding
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  // E/M pipeline register
  logic        r_reg_write;
  logic        r_mem_write;
  logic        r_result_src;
  logic [4:0]  r_rd;
  logic [31:0] r_alu_result;
  logic [31:0] r_write_data;
  logic [31:0] r_pc_plus4;

  // Datapath wires
  logic [31:0] w_src_a;
  logic [31:0] w_write_data;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_result;
  logic        w_zero;
  alu_op_e     w_alu_op;

  assign w_alu_op = alu_op_e'(ALUControlE);

  // Forward mux A. Select 10 takes the flop output ALUResultM (instruction
  // one ahead), so there is no combinational loop through the ALU.
  always_comb begin
    w_src_a = RD1_E;
    case (ForwardA_E)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = r_alu_result;
      default: w_src_a = RD1_E;
    endcase
  end

  // Forward mux B. Its output is also the store data, so a store always
  // writes the forwarded register value and never the immediate.
  always_comb begin
    w_write_data = RD2_E;
    case (ForwardB_E)
      2'b01:   w_write_data = ResultW;
      2'b10:   w_write_data = r_alu_result;
      default: w_write_data = RD2_E;
    endcase
  end

  assign w_src_b = ALUSrcE ? Imm_Ext_E : w_write_data;

  // ALU; all results truncated to 32 bits.
  always_comb begin
    w_alu_result = 32'd0;
    case (w_alu_op)
      ALU_ADD: w_alu_result = w_src_a + w_src_b;
      ALU_SUB: w_alu_result = w_src_a - w_src_b;
      ALU_AND: w_alu_result = w_src_a & w_src_b;
      ALU_OR:  w_alu_result = w_src_a | w_src_b;
      ALU_XOR: w_alu_result = w_src_a ^ w_src_b;
      ALU_SLT: w_alu_result = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
      ALU_SLL: w_alu_result = w_src_a << w_src_b[4:0];
      ALU_SRL: w_alu_result = w_src_a >> w_src_b[4:0];
      default: w_alu_result = 32'd0;
    endcase
  end

  // Zero flag only feeds branch resolution; decode selects SUB for BEQ.
  assign w_zero    = (w_alu_result == 32'd0);
  assign PCSrcE    = BranchE & w_zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // E/M register: loads every edge, reset wins and produces a NOP bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
      r_rd         <= 5'd0;
      r_alu_result <= 32'd0;
      r_write_data <= 32'd0;
      r_pc_plus4   <= 32'd0;
    end else begin
      r_reg_write  <= RegWriteE;
      r_mem_write  <= MemWriteE;
      r_result_src <= ResultSrcE;
      r_rd         <= RD_E;
      r_alu_result <= w_alu_result;
      r_write_data <= w_write_data;
      r_pc_plus4   <= PCPlus4E;
    end
  end

  assign RegWriteM  = r_reg_write;
  assign MemWriteM  = r_mem_write;
  assign ResultSrcM = r_result_src;
  assign RD_M       = r_rd;
  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign PCPlus4M   = r_pc_plus4;

endmodule

// File: doc/execute_cycle.md
# execute_cycle

Execute stage of the five-stage RISC-V pipeline, directly downstream of `decode_cycle`. It consumes the D/E pipeline outputs and resolves operand forwarding, runs the ALU, and resolves BEQ branches. It computes the branch target and registers the results into the E/M pipeline register that feeds the memory stage.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- `clk` in 1 — single pipeline clock, rising edge.
- `rst` in 1 — synchronous, active-high reset; clears the E/M register.
- `RegWriteE`, `ALUSrcE`, `MemWriteE`, `ResultSrcE`, `BranchE` in 1 each — control from decode.
- `ALUControlE` in 3 — ALU operation select.
- `RD1_E`, `RD2_E` in 32 — register-file operands from decode.
- `Imm_Ext_E` in 32 — sign-extended immediate.
- `RD_E` in 5 — destination register index.
- `PCE`, `PCPlus4E` in 32 — PC and PC+4 of the instruction in E.
- `ForwardA_E`, `ForwardB_E` in 2 — forwarding selects from the hazard unit.
- `ResultW` in 32 — writeback-stage result, used for forwarding.
- `PCSrcE` out 1 — combinational; 1 = branch taken, fetch loads `PCTargetE`.
- `PCTargetE` out 32 — combinational `PCE + Imm_Ext_E`, modulo 2^32.
- `RegWriteM`, `MemWriteM`, `ResultSrcM` out 1 — registered control.
- `RD_M` out 5 — registered destination index.
- `ALUResultM`, `WriteDataM`, `PCPlus4M` out 32 — registered data.

## Operation
- Forward mux A (`SrcAE`): 00 → `RD1_E`; 01 → `ResultW`; 10 → `ALUResultM` (current registered output); 11 → `RD1_E`.
- Forward mux B (`WriteDataE`): same encoding on `RD2_E`.
- `SrcBE` = `ALUSrcE` ? `Imm_Ext_E` : `WriteDataE`.
- The store data is always the forwarded B value, never the immediate.
- ALU, all results 32-bit with carries discarded:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: signed compare, result 1 or 0 zero-extended.
  - 110 SLL: shift amount `SrcBE[4:0]`.
  - 111 SRL: logical shift, amount `SrcBE[4:0]`.
- `ZeroE` = (ALU result == 0). It is computed on every operation and used only for branch resolution.
- `PCSrcE` = `BranchE & ZeroE`. Decode selects SUB for BEQ.
- E/M register loads on every rising edge. There is no stall or flush input; the hazard unit bubbles decode instead.
  - Loads `RegWriteM`, `MemWriteM`, `ResultSrcM` and `RD_M` from their E-stage counterparts.
  - Loads `ALUResultM` ← ALU result, `WriteDataM` ← `WriteDataE`, `PCPlus4M` ← `PCPlus4E`.

## Timing
- Reset: when `rst`=1 at a rising edge, every registered output becomes 0 on that edge. This makes a NOP bubble, since `RegWriteM`=0 and `MemWriteM`=0.
- Reset is held for as long as `rst` stays high. Reset has priority over the load.
- During reset `PCSrcE` and `PCTargetE` still follow their inputs; they are purely combinational.
- Latency: exactly one cycle from E inputs to M outputs. `PCSrcE` and `PCTargetE` have zero latency, within the same cycle.
- Forward select 10 uses the value registered on the previous edge, i.e. the instruction one ahead. There is no combinational loop: `ALUResultM` is a flop output.
- Reset mid-stream: the instruction in E at the reset edge is lost. The first post-reset edge with `rst`=0 captures normally.
- Simultaneous `BranchE`=1 and `RegWriteE`=1 is legal; both are propagated unchanged.
- Wrap-around:
  - `PCE`=0xFFFFFFFC with Imm=8 gives `PCTargetE`=0x00000004.
  - ADD 0xFFFFFFFF+1 gives 0 and sets `ZeroE`.

## Test plan
- Reset: drive nonzero inputs, `rst`=1 for 2 edges → all M outputs 0. Release, then ADD 5+7 → `ALUResultM`=12 one edge later.
- ALU sweep with A=0x80000000, B=0x00000001:
  - SUB → 0x7FFFFFFF
  - SLT → 1
  - SLL (A=1, B=31) → 0x80000000
  - SRL → 0x40000000
  - XOR → 0x80000001
- Forwarding:
  - Cycle n: ADD 3+4.
  - Cycle n+1: `ForwardA_E`=10, `RD1_E`=0, `ALUSrcE`=1, Imm=1 → `ALUResultM`=8.
  - `ForwardB_E`=01 with `ResultW`=0x55 and `MemWriteE`=1 → `WriteDataM`=0x55 even with `ALUSrcE`=1.
- Branch:
  - BEQ with RD1=RD2=9, `BranchE`=1, `PCE`=0x100, Imm=0xFFFFFFF0 → `PCSrcE`=1, `PCTargetE`=0xF0.
  - RD2=8 → `PCSrcE`=0.
  - `BranchE`=0 with equal operands → `PCSrcE`=0.
- Reset mid-stream: assert `rst` on the cycle a store (`MemWriteE`=1) is in E → `MemWriteM` stays 0. The next instruction after release registers normally.
